// File: rtl/hilo_mult_sequencer.sv
// HI/LO multiply sequencer: 32-iteration shift-add MULT/MULTU/MADD/MSUB
// plus single-cycle MTHI/MTLO writes into the architectural HI/LO pair.
//
// Ports:
//   Clk     in   1  system clock, rising-edge
//   Rst     in   1  asynchronous active-low reset
//   Start   in   1  request strobe
//   Op      in   3  0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 MTHI, 5 MTLO, 6/7 no-op
//   A       in  32  operand rs
//   B       in  32  operand rt
//   RdHiLo  in   1  pipeline is issuing mfhi/mflo this cycle
//   HI_out  out 32  architectural HI register
//   LO_out  out 32  architectural LO register
//   Busy    out  1  multiply-class operation in flight (RUN or WB)
//   Done    out  1  one-cycle pulse after HI/LO take a new product result
//   Stall   out  1  Busy & (Start | RdHiLo)

module hilo_mult_sequencer (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        RdHiLo,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic        Busy,
    output logic        Done,
    output logic        Stall
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_MADD  = 2'd2;
    localparam logic [1:0] MD_MSUB  = 2'd3;

    state_t      state;
    state_t      state_nxt;

    // Only multiply-class ops are ever latched, so two bits suffice.
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] prod;
    logic [5:0]  cnt;

    logic        idle;
    logic        accept;
    logic        wr_hi;
    logic        wr_lo;
    logic        signed_op;
    logic        negate;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [63:0] addend;
    logic [63:0] p_signed;
    logic [63:0] hilo;
    logic [63:0] wb_val;

    assign idle   = (state == IDLE);
    assign accept = idle & Start & ~Op[2];
    assign wr_hi  = idle & Start & (Op == OP_MTHI);
    assign wr_lo  = idle & Start & (Op == OP_MTLO);

    // Magnitudes: 0x80000000 negates to itself, which read unsigned is 2^31.
    assign signed_op = (op_q != MD_MULTU);
    assign mag_a     = (signed_op & a_q[31]) ? (~a_q + 32'd1) : a_q;
    assign mag_b     = (signed_op & b_q[31]) ? (~b_q + 32'd1) : b_q;
    assign negate    = signed_op & (a_q[31] ^ b_q[31]);

    // One partial product per iteration: bit cnt of B selects A << cnt.
    assign addend = mag_b[cnt[4:0]] ? ({32'd0, mag_a} << cnt[4:0]) : 64'd0;

    assign p_signed = negate ? (~prod + 64'd1) : prod;
    assign hilo     = {HI_out, LO_out};

    always_comb begin
        wb_val = p_signed;
        unique case (op_q)
            MD_MULT:  wb_val = p_signed;
            MD_MULTU: wb_val = p_signed;
            MD_MADD:  wb_val = hilo + p_signed;
            MD_MSUB:  wb_val = hilo - p_signed;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (cnt == 6'd31) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Busy <= 1'b0;
            Done <= 1'b0;
        end else begin
            Busy <= (state_nxt == RUN) | (state_nxt == WB);
            Done <= (state == WB);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            op_q <= 2'd0;
            a_q  <= 32'd0;
            b_q  <= 32'd0;
            prod <= 64'd0;
            cnt  <= 6'd0;
        end else begin
            if (accept) begin
                op_q <= Op[1:0];
                a_q  <= A;
                b_q  <= B;
                prod <= 64'd0;
                cnt  <= 6'd0;
            end else if (state == RUN) begin
                prod <= prod + addend;
                cnt  <= cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            HI_out <= 32'd0;
            LO_out <= 32'd0;
        end else begin
            if (state == WB) begin
                HI_out <= wb_val[63:32];
                LO_out <= wb_val[31:0];
            end else begin
                if (wr_hi) begin
                    HI_out <= A;
                end
                if (wr_lo) begin
                    LO_out <= A;
                end
            end
        end
    end

    // Gated by Rst so the stall request drops the moment reset asserts.
    assign Stall = Rst & Busy & (Start | RdHiLo);

endmodule

// File: tb/tb_hilo_mult_sequencer.sv
// Self-checking bench for hilo_mult_sequencer: directed cases plus random
// operations compared against a 64-bit arithmetic model of HI/LO.

module tb_hilo_mult_sequencer;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        RdHiLo;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic        Busy;
    logic        Done;
    logic        Stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    hilo_mult_sequencer dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Start  (Start),
        .Op     (Op),
        .A      (A),
        .B      (B),
        .RdHiLo (RdHiLo),
        .HI_out (HI_out),
        .LO_out (LO_out),
        .Busy   (Busy),
        .Done   (Done),
        .Stall  (Stall)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic on the architectural pair.
    function automatic void model(input logic [2:0] op,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0] ps;
        logic [63:0] pu;
        logic [63:0] acc;
        sa  = $signed(a);
        sb  = $signed(b);
        ps  = sa * sb;
        pu  = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        case (op)
            3'd0: acc = ps;
            3'd1: acc = pu;
            3'd2: acc = acc + ps;
            3'd3: acc = acc - ps;
            3'd4: acc[63:32] = a;
            3'd5: acc[31:0] = a;
            default: ;
        endcase
        m_hi = acc[63:32];
        m_lo = acc[31:0];
    endfunction

    // Issue one op (Start accepted at the next edge, E0) and follow it to
    // completion; returns in the Done cycle for multiply-class ops.
    task automatic run(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
        logic [63:0] old;
        old   = {m_hi, m_lo};
        Start = 1'b1;
        Op    = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        model(op, a, b);
        if (op < 3'd4) begin
            check("busy_e0", 64'(Busy), 64'd1);
            check("done_e0", 64'(Done), 64'd0);
            for (int i = 1; i <= 32; i++) begin
                tick();
                check("busy_run", 64'(Busy), 64'd1);
                check("done_run", 64'(Done), 64'd0);
                check("hilo_hold", {HI_out, LO_out}, old);
            end
            tick();
            check("busy_e33", 64'(Busy), 64'd0);
            check("done_e33", 64'(Done), 64'd1);
            check("hilo_wb", {HI_out, LO_out}, {m_hi, m_lo});
        end else begin
            check("busy_mt", 64'(Busy), 64'd0);
            check("done_mt", 64'(Done), 64'd0);
            check("hilo_mt", {HI_out, LO_out}, {m_hi, m_lo});
        end
    endtask

    initial begin
        logic [63:0] first;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rop;

        Rst    = 1'b1;
        Start  = 1'b1;
        RdHiLo = 1'b1;
        Op     = 3'd0;
        A      = 32'd0;
        B      = 32'd0;
        #3 Rst = 1'b0;
        #1;
        check("rst_hilo", {HI_out, LO_out}, 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_stall", 64'(Stall), 64'd0);
        tick();
        check("rst_hold", {HI_out, LO_out}, 64'd0);
        Start  = 1'b0;
        RdHiLo = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;

        run(3'd0, 32'hFFFF_FFFD, 32'd5);
        check("mult_neg", {HI_out, LO_out}, 64'hFFFF_FFFF_FFFF_FFF1);
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max", {HI_out, LO_out}, 64'hFFFF_FFFE_0000_0001);
        run(3'd0, 32'h8000_0000, 32'h8000_0000);
        check("mult_min", {HI_out, LO_out}, 64'h4000_0000_0000_0000);
        run(3'd4, 32'd0, 32'd0);
        run(3'd5, 32'd10, 32'd0);
        run(3'd2, 32'd2, 32'd3);
        check("madd", {HI_out, LO_out}, 64'd16);
        run(3'd6, 32'h1234_5678, 32'd0);
        run(3'd7, 32'h9ABC_DEF0, 32'd0);
        check("nop", {HI_out, LO_out}, 64'd16);
        run(3'd4, 32'd0, 32'd0);
        run(3'd5, 32'd0, 32'd0);
        run(3'd3, 32'd1, 32'd1);
        check("msub", {HI_out, LO_out}, 64'hFFFF_FFFF_FFFF_FFFF);

        // Second request and mfhi/mflo while busy: stalled and ignored.
        rb    = 32'h0001_2345;
        Start = 1'b1;
        Op    = 3'd0;
        A     = 32'hFFFF_0101;
        B     = rb;
        tick();
        Start = 1'b0;
        model(3'd0, 32'hFFFF_0101, rb);
        first = {m_hi, m_lo};
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 10) begin
                RdHiLo = 1'b1;
                Start  = 1'b1;
                Op     = 3'd0;
                A      = 32'd7;
                #1;
                check("stall_hi", 64'(Stall), 64'd1);
            end else if (i == 11 || i == 12) begin
                check("stall_hold", 64'(Stall), 64'd1);
            end else if (i == 13) begin
                RdHiLo = 1'b0;
                Start  = 1'b0;
                #1;
                check("stall_lo", 64'(Stall), 64'd0);
            end
            check("busy_stl", 64'(Busy), 64'd1);
        end
        tick();
        check("done_stl", 64'(Done), 64'd1);
        check("first_kept", {HI_out, LO_out}, first);
        run(3'd0, 32'd7, rb);
        check("reissue", 64'(LO_out), 64'(32'd7 * rb));

        // Reset in the middle of a multiply.
        Start = 1'b1;
        Op    = 3'd0;
        A     = 32'd1234;
        B     = 32'd5678;
        tick();
        Start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
        end
        RdHiLo = 1'b1;
        #2 Rst = 1'b0;
        #1;
        check("abort_hilo", {HI_out, LO_out}, 64'd0);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_stall", 64'(Stall), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        RdHiLo = 1'b0;
        tick();
        @(negedge Clk);
        Rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort_nodone", 64'(Done), 64'd0);
        end
        run(3'd0, 32'd1234, 32'd5678);
        check("post_rst", {HI_out, LO_out}, 64'd7006652);

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (n % 5 == 0) ra = 32'h8000_0000;
            run(rop, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_mult_sequencer.md
HILO_MULT_SEQUENCER -- requirements
Module: hilo_mult_sequencer

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-low reset; ports are listed clock and reset first.
REQ-002 Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Rst  input  1  asynchronous active-low reset; 0 resets the block immediately, independent of Clk.
REQ-004 Start  input  1  request strobe; sampled on the rising edge of Clk.
REQ-005 Op  input  3  operation code: 0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 MTHI, 5 MTLO; 6 and 7 are no-ops.
REQ-006 A  input  32  operand rs.
REQ-007 B  input  32  operand rt.
REQ-008 RdHiLo  input  1  pipeline is issuing mfhi or mflo this cycle.
REQ-009 HI_out  output  32  architectural HI register.
REQ-010 LO_out  output  32  architectural LO register.
REQ-011 Busy  output  1  a multiply-class operation is in flight.
REQ-012 Done  output  1  one-cycle pulse; HI_out and LO_out hold the new result.
REQ-013 Stall  output  1  combinational: Busy & (Start | RdHiLo).

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and WB.
REQ-015 In IDLE, Start with Op 0-3 SHALL latch A, B and Op, clear a 64-bit product and a 6-bit counter, and enter RUN.
REQ-016 In IDLE, Start with Op 4 SHALL write HI<=A, and Op 5 SHALL write LO<=A, at that edge; the FSM stays in IDLE, Busy stays 0 and Done stays 0.
REQ-017 In IDLE, Start with Op 6 or 7 SHALL have no effect.
REQ-018 RUN SHALL perform exactly 32 shift-add iterations, one per edge, on unsigned magnitudes; the counter increments 0..31, and the edge at count 31 moves the FSM to WB.
REQ-019 For Op 0, 2 and 3, each operand's magnitude SHALL be its absolute value (0x80000000 maps to 2^31); the 64-bit product is negated in two's complement when A[31]^B[31]=1.
REQ-020 For Op 1, A and B SHALL be treated as unsigned and no negation applied.
REQ-021 The WB edge SHALL write {HI,LO}: P for Op 0/1, {HI,LO}+P for Op 2, and {HI,LO}-P for Op 3.
REQ-022 In REQ-021, P is the signed 64-bit product, {HI,LO} are the register values at the WB edge, and arithmetic is mod 2^64.
REQ-023 After the WB edge, the FSM SHALL return to IDLE and Done SHALL be 1 for exactly one cycle.
REQ-024 Latency: for Start accepted at edge E0, Busy SHALL be 1 from E0 to E33, HI/LO update at E33, and Done=1 in the cycle after E33.
REQ-025 Busy SHALL be 1 exactly in RUN and WB.
REQ-026 Start asserted while Busy=1 SHALL be ignored; the latched operands and Op are unaffected, and Stall is raised so the requester holds Start until Busy=0.
REQ-027 HI_out and LO_out SHALL be the registers driven directly; they SHALL NOT change except on reset, an MTHI/MTLO edge, or the WB edge.
REQ-028 Start is accepted in the cycle Done=1, since the FSM is IDLE then; back-to-back operations SHALL therefore be spaced 34 cycles apart.
REQ-029 Busy, Done and the FSM state SHALL be registered outputs; Stall is the only combinational output.

Reset
REQ-030 Rst=0 SHALL force, asynchronously: HI=0, LO=0, FSM=IDLE, Busy=0, Done=0, product=0, counter=0.
REQ-031 A reset asserted during RUN or WB SHALL abort the operation with no HI/LO write; after release the block accepts a new Start on the first edge.
REQ-032 Stall SHALL be 0 while Rst=0.

Verification
REQ-033 MULT with A=0xFFFFFFFD, B=5 -> at E33 HI=0xFFFFFFFF, LO=0xFFFFFFF1; Done high one cycle; Busy high from E0 to E33.
REQ-034 MULTU with A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; MULT with A=B=0x80000000 -> HI=0x40000000, LO=0.
REQ-035 MTHI with A=0, then MTLO with A=10, then MADD with A=2, B=3 -> HI=0, LO=16.
REQ-036 From HI=LO=0, MSUB with A=1, B=1 -> HI=LO=0xFFFFFFFF.
REQ-037 RdHiLo=1 and a second Start (Op 0, A=7) at iteration 10 -> Stall=1 in those cycles and the first result is unchanged; after Done, re-issuing the Start gives LO=7*B.
REQ-038 Rst=0 at iteration 10 of a MULT -> HI=LO=0, Busy=0, Done never pulses; a MULT issued after release completes normally in 34 cycles.
